// File: rtl/triangle_area_seq.sv
// triangle_area_seq: twice-area (|shoelace determinant|) of one triangle using one shared XW x YW multiplier.
// Latency: out_valid rises on the 8th edge counting the accept edge as the 1st; one triangle per 9 cycles minimum.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Define TRI_HALF_AREA_EN to return |det|>>1.
module triangle_area_seq #(
  parameter int XW = 9,
  parameter int YW = 7
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] ax,
  input  logic [XW-1:0] bx,
  input  logic [XW-1:0] cx,
  input  logic [YW-1:0] ay,
  input  logic [YW-1:0] by,
  input  logic [YW-1:0] cy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW+YW:0] area,
  output logic          busy
);

  localparam int PW   = XW + YW;
  localparam int ACCW = XW + YW + 3;
  localparam int AW   = XW + YW + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ABS, S_DONE} state_t;

  state_t state, state_nxt;

  logic [2:0]             step;
  logic [XW-1:0]          ax_r, bx_r, cx_r;
  logic [YW-1:0]          ay_r, by_r, cy_r;
  logic signed [ACCW-1:0] acc;

  logic [XW-1:0]          op_x;
  logic [YW-1:0]          op_y;
  logic [PW-1:0]          prod;
  logic signed [ACCW-1:0] prod_ext;
  logic                   step_sub;
  logic [AW-1:0]          mag;
  logic [AW-1:0]          area_nxt;

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: six multiply steps, one abs step, then hold until the result is taken
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid)        state_nxt = S_MUL;
      S_MUL:  if (step == 3'd5)    state_nxt = S_ABS;
      S_ABS:                       state_nxt = S_DONE;
      S_DONE: if (out_ready)       state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    in_ready = (state == S_IDLE);
    busy     = (state != S_IDLE);
  end

  // Operand select for the shared multiplier: steps 0-2 are the positive terms, 3-5 the negative ones
  always_comb begin
    op_x = ax_r;
    op_y = by_r;
    case (step)
      3'd0:    begin op_x = ax_r; op_y = by_r; end
      3'd1:    begin op_x = cx_r; op_y = ay_r; end
      3'd2:    begin op_x = bx_r; op_y = cy_r; end
      3'd3:    begin op_x = bx_r; op_y = ay_r; end
      3'd4:    begin op_x = ax_r; op_y = cy_r; end
      3'd5:    begin op_x = cx_r; op_y = by_r; end
      default: begin op_x = ax_r; op_y = by_r; end
    endcase
  end

  assign prod     = {{YW{1'b0}}, op_x} * {{XW{1'b0}}, op_y};
  assign prod_ext = signed'({3'b000, prod});
  assign step_sub = (step >= 3'd3);

  // Magnitude of the determinant; it always fits in AW bits so truncation is lossless
  always_comb begin
    mag = acc[ACCW-1] ? AW'(-acc) : AW'(acc);
`ifdef TRI_HALF_AREA_EN
    area_nxt = mag >> 1;
`else
    area_nxt = mag;
`endif
  end

  // Datapath: capture on accept, accumulate one product per MUL cycle, publish in ABS, clear on output handshake
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      step      <= '0;
      acc       <= '0;
      area      <= '0;
      out_valid <= 1'b0;
      ax_r      <= '0;
      bx_r      <= '0;
      cx_r      <= '0;
      ay_r      <= '0;
      by_r      <= '0;
      cy_r      <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          ax_r <= ax;
          bx_r <= bx;
          cx_r <= cx;
          ay_r <= ay;
          by_r <= by;
          cy_r <= cy;
          acc  <= '0;
          step <= '0;
        end
        S_MUL: begin
          acc  <= step_sub ? (acc - prod_ext) : (acc + prod_ext);
          step <= step + 3'd1;
        end
        S_ABS: begin
          area      <= area_nxt;
          out_valid <= 1'b1;
        end
        S_DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
